// File: rtl/flash_pkg.sv
// Shared constants and state encoding for the serial-flash read controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flash_pkg;
   localparam logic [7:0] CmdRead  = 8'h03;
   localparam int         AddrBits = 24;
   localparam int         CmdBits  = 8;

   typedef enum logic [2:0] {
      Idle    = 3'd0,
      Command = 3'd1,
      Address = 3'd2,
      Data    = 3'd3,
      Gap     = 3'd4
   } flash_ctrl_state_e;
endpackage

// File: rtl/flash_arbiter.sv
// Two-port request arbiter holding the one-hot grant; FLASH_READ_CTRL_ROUND_ROBIN_EN selects round-robin.
// Latency: win is combinational, gnt registers on the take strobe.
// Backpressure: losers keep req high and are reconsidered at the next take.
module flash_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   input  logic       drop,
   output logic [1:0] win,
   output logic [1:0] gnt
);
`ifdef FLASH_READ_CTRL_ROUND_ROBIN_EN
   logic last_q;

   // With both requesting, the port not served last wins; resets favouring port 0.
   always_comb begin
      win = req;
      if (req == 2'b11) begin
         win = last_q ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (take) begin
         last_q <= win[1];
      end
   end
`else
   always_comb begin
      win = req[0] ? 2'b01 : {req[1], 1'b0};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt <= 2'b00;
      end else if (take) begin
         gnt <= win;
      end else if (drop) begin
         gnt <= 2'b00;
      end
   end
endmodule

// File: rtl/flash_read_ctrl.sv
// SPI READ (0x03) burst controller and 2-port arbiter for the P25Q32U; FLASH_READ_CTRL_ROUND_ROBIN_EN selects round-robin.
// Latency: first data_valid 40 cycles after the grant edge, then one byte every 8 cycles.
// Backpressure: none toward clients (every data_valid must be taken); pending requests wait in Idle.
module flash_read_ctrl
   import flash_pkg::*;
#(
   parameter int LenWidth = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req,
   input  logic [23:0]         addr0,
   input  logic [23:0]         addr1,
   input  logic [LenWidth-1:0] len0,
   input  logic [LenWidth-1:0] len1,
   output logic [1:0]          gnt,
   output logic                busy,
   output logic [7:0]          data,
   output logic                data_valid,
   output logic                done,
   output logic                cs_n,
   output logic                mosi,
   input  logic                miso
);
   localparam logic [2:0] StIdle    = Idle;
   localparam logic [2:0] StCommand = Command;
   localparam logic [2:0] StAddress = Address;
   localparam logic [2:0] StData    = Data;
   localparam logic [2:0] StGap     = Gap;

   logic [2:0]          state_q;
   logic [4:0]          bit_cnt_q;
   logic [LenWidth-1:0] byte_cnt_q;
   logic [AddrBits-1:0] addr_q;
   logic [7:0]          shift_q;
   logic [1:0]          win;
   logic                take;
   logic                last_byte;

   assign take      = (state_q == StIdle) && (req != 2'b00);
   assign last_byte = (state_q == StData) && (bit_cnt_q == 5'd8) && (byte_cnt_q == '0);

   flash_arbiter u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .take  (take),
      .drop  (last_byte),
      .win   (win),
      .gnt   (gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         addr_q     <= '0;
         shift_q    <= '0;
         busy       <= 1'b0;
         cs_n       <= 1'b1;
         mosi       <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         done       <= 1'b0;
         case (state_q)
            StIdle: begin
               if (take) begin
                  addr_q     <= win[1] ? addr1 : addr0;
                  byte_cnt_q <= win[1] ? len1 : len0;
                  busy       <= 1'b1;
                  cs_n       <= 1'b0;
                  mosi       <= CmdRead[7];
                  bit_cnt_q  <= 5'(CmdBits - 2);
                  state_q    <= StCommand;
               end
            end
            StCommand: begin
               mosi <= CmdRead[bit_cnt_q[2:0]];
               if (bit_cnt_q == 5'd0) begin
                  bit_cnt_q <= 5'(AddrBits - 1);
                  state_q   <= StAddress;
               end else begin
                  bit_cnt_q <= bit_cnt_q - 5'd1;
               end
            end
            StAddress: begin
               mosi <= addr_q[bit_cnt_q];
               if (bit_cnt_q == 5'd0) begin
                  state_q <= StData;
               end else begin
                  bit_cnt_q <= bit_cnt_q - 5'd1;
               end
            end
            StData: begin
               // A completed byte is published one edge after its 8th sample,
               // while that same edge already takes bit 7 of the next byte.
               mosi    <= 1'b0;
               shift_q <= {shift_q[6:0], miso};
               if (bit_cnt_q == 5'd8) begin
                  data       <= shift_q;
                  data_valid <= 1'b1;
                  bit_cnt_q  <= 5'd1;
                  if (byte_cnt_q == '0) begin
                     done    <= 1'b1;
                     cs_n    <= 1'b1;
                     state_q <= StGap;
                  end else begin
                     byte_cnt_q <= byte_cnt_q - 1'b1;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 5'd1;
               end
            end
            StGap: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end
endmodule
